// File: rtl/bram_pkg.sv
// bram_pkg: FSM state, BRAM read latency, FIFO depth and address step shared by the burst reader (BRAM_READ_LAT2_EN selects 2-cycle latency / depth 3)
package bram_pkg;
    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;
`ifdef BRAM_READ_LAT2_EN
    localparam int RD_LAT = 2;
    localparam int FIFO_DEPTH = 3;
`else
    localparam int RD_LAT = 1;
    localparam int FIFO_DEPTH = 2;
`endif
    localparam int ADDR_STEP = 4;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
endpackage

// File: rtl/bram_rd_fifo.sv
// bram_rd_fifo: small circular buffer for BRAM read data with full/empty flags and occupancy count
module bram_rd_fifo #(
    parameter int DEPTH = 2,
    parameter int W = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic [W-1:0]                 din,
    output logic [W-1:0]                 dout,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          do_push, do_pop;
    assign empty = cnt_q == '0;
    assign full  = cnt_q == CW'(DEPTH);
    assign count = cnt_q;
    assign dout  = mem_q[rd_q];
    // pointer and occupancy update; a push into a full buffer is taken only together with a pop
    always_comb begin
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
        rd_d    = do_pop ? (rd_q == PW'(DEPTH - 1) ? '0 : rd_q + PW'(1)) : rd_q;
        wr_d    = do_push ? (wr_q == PW'(DEPTH - 1) ? '0 : wr_q + PW'(1)) : wr_q;
        cnt_d   = cnt_q + CW'(do_push) - CW'(do_pop);
    end
    // storage and pointers; reset clears the contents so the head reads zero
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) mem_q[wr_q] <= din;
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/bram_burst_reader.sv
// bram_burst_reader: reads len consecutive words from BRAM at base_addr and streams them out in order (BRAM_READ_LAT2_EN: 2-cycle BRAM latency, 3-deep buffer)
module bram_burst_reader #(
    parameter int BRAM_ADDR_BIT = 32,
    parameter int BRAM_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [BRAM_ADDR_BIT-1:0] base_addr,
    input  logic [15:0]              len,
    output logic                     busy,
    output logic                     done,
    output logic                     BRAM_clk,
    output logic [BRAM_ADDR_BIT-1:0] BRAM_addr,
    output logic [BRAM_WIDTH-1:0]    BRAM_din,
    output logic                     BRAM_en,
    output logic                     BRAM_rst,
    output logic [3:0]               BRAM_wen,
    input  logic [BRAM_WIDTH-1:0]    BRAM_dout,
    output logic [BRAM_WIDTH-1:0]    m_data,
    output logic                     m_valid,
    input  logic                     m_ready
);
    import bram_pkg::*;
    localparam logic [BRAM_ADDR_BIT-1:0] STEP = BRAM_ADDR_BIT'(ADDR_STEP);
    state_t                   state_q, state_d;
    logic [BRAM_ADDR_BIT-1:0] addr_q, addr_d, addr_c;
    logic [15:0]              rem_q, rem_d;
    logic [RD_LAT-1:0]        pipe_q;
    logic                     done_q, issue, space, pop, fifo_full, fifo_empty;
    logic [CNT_W-1:0]         fifo_cnt;
    logic [3:0]               occ;
    assign BRAM_clk  = clk;
    assign BRAM_din  = '0;
    assign BRAM_rst  = 1'b0;
    assign BRAM_wen  = 4'b0000;
    assign BRAM_en   = issue;
    assign BRAM_addr = addr_c;
    assign busy      = state_q != IDLE;
    assign done      = done_q;
    assign m_valid   = !fifo_empty;
    assign pop       = m_valid && m_ready;
    // next state and read issue; the first read goes out in the start cycle, later ones only while buffer room remains after this cycle's pop
    always_comb begin
        occ = 4'(fifo_cnt) - 4'(pop);
        for (int i = 0; i < RD_LAT; i++) occ = occ + 4'(pipe_q[i]);
        space   = occ < 4'(FIFO_DEPTH) && (!fifo_full || pop);
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        addr_c  = addr_q;
        issue   = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                addr_c  = base_addr;
                issue   = len != '0;
                addr_d  = base_addr + STEP;
                rem_d   = len - 16'd1;
                state_d = issue ? READ : DONE;
            end
            READ: begin
                issue = space && rem_q != '0;
                if (issue) begin
                    addr_d = addr_q + STEP;
                    rem_d  = rem_q - 16'd1;
                end
                if (rem_d == '0) state_d = DRAIN;
            end
            DRAIN: if (pipe_q == '0 && fifo_empty) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (rst) begin
            issue  = 1'b0;
            addr_c = '0;
        end
    end
    // state, address counter, in-flight read tracking and the registered done pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            pipe_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            pipe_q  <= RD_LAT'({pipe_q, issue});
            done_q  <= state_q == DONE;
        end
    end
    bram_rd_fifo #(.DEPTH(FIFO_DEPTH), .W(BRAM_WIDTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (pipe_q[RD_LAT-1]),
        .pop   (pop),
        .din   (BRAM_dout),
        .dout  (m_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_cnt)
    );
endmodule

// File: tb/tb_bram_burst_reader.sv
// tb_bram_burst_reader: vector table, random bursts and abort/intrusion sequences checked against an address-order reference model
module tb_bram_burst_reader;
`ifdef BRAM_READ_LAT2_EN
    localparam int LAT = 2;
    localparam int DEPTH = 3;
`else
    localparam int LAT = 1;
    localparam int DEPTH = 2;
`endif
    typedef struct {
        logic [31:0] base;
        int          len;
        int          mode;
        int          intrude;
        int          exp_lat;
    } vec_t;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        m_ready = 1'b0;
    logic [31:0] base_addr = '0;
    logic [15:0] len = '0;
    logic        busy, done, BRAM_clk, BRAM_en, BRAM_rst, m_valid;
    logic [31:0] BRAM_addr, BRAM_din, BRAM_dout, m_data;
    logic [3:0]  BRAM_wen;
    logic [31:0] d1, d2;
    logic [31:0] got_addr[$];
    logic [31:0] got_data[$];
    int checks = 0, failures = 0, cyc = 0, mode = 0;
    int done_cnt, done_cyc, first_valid, iss, del, ovf, const_bad;
    vec_t vecs[7];

    always #5 clk = ~clk;

    bram_burst_reader #(.BRAM_ADDR_BIT(32), .BRAM_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .len(len),
        .busy(busy), .done(done), .BRAM_clk(BRAM_clk), .BRAM_addr(BRAM_addr),
        .BRAM_din(BRAM_din), .BRAM_en(BRAM_en), .BRAM_rst(BRAM_rst), .BRAM_wen(BRAM_wen),
        .BRAM_dout(BRAM_dout), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready)
    );

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return a * 32'h9E37_79B1 + 32'h0123_4567;
    endfunction

    always @(posedge clk) begin
        if (BRAM_en) d1 <= mem_f(BRAM_addr);
        d2 <= d1;
    end
    assign BRAM_dout = LAT == 2 ? d2 : d1;

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    task automatic chk(input string name, input bit ok, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear();
        got_addr.delete();
        got_data.delete();
        done_cnt = 0;
        done_cyc = -1;
        first_valid = -1;
        iss = 0;
        del = 0;
        ovf = 0;
        const_bad = 0;
    endtask

    task automatic tick();
        @(negedge clk);
        if (BRAM_wen != 4'b0000 || BRAM_din != '0 || BRAM_rst || BRAM_clk != clk) const_bad++;
        if (!rst) begin
            if (BRAM_en) begin
                got_addr.push_back(BRAM_addr);
                iss++;
            end
            if (m_valid && m_ready) begin
                got_data.push_back(m_data);
                del++;
            end
            if (m_valid && first_valid < 0) first_valid = cyc;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (iss - del > DEPTH) ovf++;
        end
        @(posedge clk);
        #1;
        cyc++;
        m_ready = mode == 0 ? 1'b1 : mode == 1 ? ~m_ready : 1'($urandom_range(0, 1));
    endtask

    task automatic check_reset_state();
        chk("rst_busy", busy == 1'b0, 32'(busy), 0);
        chk("rst_done", done == 1'b0, 32'(done), 0);
        chk("rst_m_valid", m_valid == 1'b0, 32'(m_valid), 0);
        chk("rst_bram_en", BRAM_en == 1'b0, 32'(BRAM_en), 0);
        chk("rst_bram_addr", BRAM_addr == '0, BRAM_addr, 0);
        chk("rst_m_data", m_data == '0, m_data, 0);
    endtask

    task automatic run_burst(input vec_t v);
        int s_cyc, n, bad_a, bad_d;
        logic [31:0] ea;
        clear();
        mode = v.mode;
        m_ready = mode == 2 ? 1'($urandom_range(0, 1)) : 1'b1;
        start = 1'b1;
        base_addr = v.base;
        len = 16'(v.len);
        s_cyc = cyc;
        tick();
        start = 1'b0;
        base_addr = $urandom;
        len = 16'($urandom);
        #2;
        chk("busy_after_start", busy == 1'b1, 32'(busy), 1);
        n = 0;
        while (done_cnt == 0 && n < 40 + 8 * v.len) begin
            start = v.intrude > 0 && n == v.intrude;
            if (start) begin
                base_addr = $urandom;
                len = 16'($urandom_range(1, 9));
            end
            tick();
            n++;
        end
        start = 1'b0;
        repeat (4) tick();
        bad_a = -1;
        bad_d = -1;
        for (int k = 0; k < v.len; k++) begin
            ea = v.base + 32'(4 * k);
            if (bad_a < 0 && (k >= got_addr.size() || got_addr[k] != ea)) bad_a = k;
            if (bad_d < 0 && (k >= got_data.size() || got_data[k] != mem_f(ea))) bad_d = k;
        end
        chk("addr_count", got_addr.size() == v.len, 32'(got_addr.size()), 32'(v.len));
        chk("addr_order", bad_a < 0, bad_a < 0 || bad_a >= got_addr.size() ? 32'(bad_a) : got_addr[bad_a],
            v.base + 32'(4 * bad_a));
        chk("beat_count", got_data.size() == v.len, 32'(got_data.size()), 32'(v.len));
        chk("data_order", bad_d < 0, bad_d < 0 || bad_d >= got_data.size() ? 32'(bad_d) : got_data[bad_d],
            mem_f(v.base + 32'(4 * bad_d)));
        chk("done_once", done_cnt == 1, 32'(done_cnt), 1);
        chk("no_overflow", ovf == 0, 32'(ovf), 0);
        chk("bram_const", const_bad == 0, 32'(const_bad), 0);
        chk("idle_after", busy == 1'b0, 32'(busy), 0);
        if (v.exp_lat >= 0) chk("first_valid_lat", first_valid - s_cyc == v.exp_lat, 32'(first_valid - s_cyc), 32'(v.exp_lat));
        if (v.len == 0) begin
            chk("len0_done_lat", done_cyc - s_cyc == 2, 32'(done_cyc - s_cyc), 2);
            chk("len0_no_valid", first_valid < 0, 32'(first_valid), 32'(-1));
        end
    endtask

    initial begin
        int n, nb, ni;
        vec_t v;
        vecs[0] = '{32'h0000_0100, 4, 0, 0, LAT + 1};
        vecs[1] = '{32'h0000_0000, 0, 0, 0, -1};
        vecs[2] = '{32'h0000_0200, 8, 1, 0, -1};
        vecs[3] = '{32'hFFFF_FFF8, 3, 0, 0, LAT + 1};
        vecs[4] = '{32'h0000_0400, 5, 1, 2, -1};
        vecs[5] = '{32'h0000_0044, 1, 0, 0, LAT + 1};
        vecs[6] = '{32'h0000_1000, 12, 2, 3, -1};
        @(posedge clk);
        #1;
        clear();
        repeat (3) tick();
        rst = 1'b0;
        #2;
        check_reset_state();
        tick();
        for (int i = 0; i < 7; i++) run_burst(vecs[i]);
        clear();
        mode = 0;
        m_ready = 1'b1;
        start = 1'b1;
        base_addr = 32'h0000_0300;
        len = 16'd6;
        tick();
        start = 1'b0;
        n = 0;
        while (got_data.size() < 2 && n < 40) begin
            tick();
            n++;
        end
        chk("abort_reached_beat3", got_data.size() == 2, 32'(got_data.size()), 2);
        if (got_data.size() == 2)
            chk("abort_prefix", got_data[0] == mem_f(32'h300) && got_data[1] == mem_f(32'h304), got_data[1], mem_f(32'h304));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #2;
        check_reset_state();
        done_cnt = 0;
        nb = got_data.size();
        ni = got_addr.size();
        repeat (8) tick();
        chk("abort_no_done", done_cnt == 0, 32'(done_cnt), 0);
        chk("abort_no_beats", got_data.size() == nb, 32'(got_data.size()), 32'(nb));
        chk("abort_no_reads", got_addr.size() == ni, 32'(got_addr.size()), 32'(ni));
        run_burst('{32'h0000_0500, 6, 0, 0, LAT + 1});
        for (int i = 0; i < 10; i++) begin
            v.base = $urandom_range(0, 3) == 0 ? 32'hFFFF_FFF0 + 32'(4 * $urandom_range(0, 3)) : $urandom & 32'hFFFF_FFFC;
            v.len = $urandom_range(0, 12);
            v.mode = 2;
            v.intrude = v.len >= 4 ? 2 : 0;
            v.exp_lat = -1;
            run_burst(v);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/bram_burst_reader.md
BRAM_BURST_READER -- requirements
Module: bram_burst_reader

Interface
REQ-001 Parameter BRAM_ADDR_BIT, default 32, SHALL set the BRAM byte-address width.
REQ-002 Parameter BRAM_WIDTH, default 32, SHALL set the data word width; only 32 is supported.
REQ-003 clk  in  1  SHALL be the single clock; BRAM_clk SHALL be driven from clk.
REQ-004 rst  in  1  SHALL be the synchronous, active-high reset.
REQ-005 start  in  1  SHALL be a one-cycle command pulse.
REQ-006 base_addr  in  BRAM_ADDR_BIT  SHALL give the byte address of the first word, sampled on start.
REQ-007 len  in  16  SHALL give the word count, sampled on start.
REQ-008 busy  out  1  SHALL be high from the cycle after an accepted start until done.
REQ-009 done  out  1  SHALL be a one-cycle pulse after the last word is accepted downstream.
REQ-010 BRAM_addr, BRAM_din, BRAM_en, BRAM_rst, BRAM_wen  out  BRAM_ADDR_BIT/BRAM_WIDTH/1/1/4  SHALL form the BRAM master port; BRAM_dout  in  BRAM_WIDTH.
REQ-011 m_data  out  BRAM_WIDTH, m_valid  out  1, m_ready  in  1  SHALL form the output stream.

Function
REQ-012 BRAM_wen SHALL be 4'b0000, BRAM_din SHALL be 0 and BRAM_rst SHALL be 0 at all times.
REQ-013 FSM states: IDLE, READ, DRAIN, DONE.
REQ-014 IDLE SHALL go to READ on start with len!=0, and to DONE on start with len==0.
REQ-015 READ SHALL go to DRAIN in the cycle the last read is issued.
REQ-016 DRAIN SHALL go to DONE when no read is in flight and the buffer is empty.
REQ-017 DONE SHALL assert done for one cycle, then return to IDLE.
REQ-018 start SHALL be ignored in every state other than IDLE.
REQ-019 A read issue SHALL be BRAM_en=1 with BRAM_addr = base_addr + 4*k, for k = 0..len-1.
REQ-020 Address addition SHALL wrap modulo 2^BRAM_ADDR_BIT.
REQ-021 Read data SHALL be captured from BRAM_dout exactly one cycle after its issue into a 2-entry FIFO.
REQ-022 A read SHALL issue only when (FIFO occupancy + reads in flight) < FIFO depth, so no data is ever dropped.
REQ-023 m_valid SHALL equal FIFO non-empty; m_data SHALL be the FIFO head; a transfer SHALL occur when m_valid&m_ready.
REQ-024 With m_ready held high, throughput SHALL be one word per cycle and first m_valid SHALL occur 2 cycles after start.
REQ-025 Simultaneous FIFO push and pop SHALL keep the occupancy unchanged.
REQ-026 Words SHALL be delivered in address order.

Reset
REQ-027 rst SHALL override every other input.
REQ-028 rst mid-burst SHALL abort the burst, flush the FIFO and discard in-flight data, without pulsing done.
REQ-029 After reset: state=IDLE; busy, done, m_valid and BRAM_en =0; BRAM_addr=0; m_data=0.

Configuration
REQ-030 Macro BRAM_READ_LAT2_EN SHALL, when defined, select a BRAM read latency of 2 cycles and a FIFO depth of 3.
REQ-031 With BRAM_READ_LAT2_EN, first m_valid SHALL occur 3 cycles after start.
REQ-032 Without BRAM_READ_LAT2_EN, read latency SHALL be 1 and FIFO depth 2, as in REQ-021/024.

Structure
REQ-033 Package bram_pkg SHALL hold the FSM state enum, the read-latency and FIFO-depth constants, and the address-step constant (4).
REQ-034 Sub-module bram_rd_fifo (parameterised depth, with push, pop, full, empty and count) SHALL implement the buffer.

Verification
REQ-035 base_addr=0x100, len=4, m_ready=1 -> addresses 0x100, 0x104, 0x108, 0x10C on consecutive cycles; 4 beats; done exactly once.
REQ-036 len=0 -> no BRAM_en; done pulses 2 cycles after start; m_valid stays 0.
REQ-037 len=8, m_ready toggling 1010... -> all 8 words in order; FIFO never overflows; BRAM_en held low while FIFO+in-flight=2.
REQ-038 base_addr=0xFFFFFFF8, len=3 -> addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
REQ-039 rst asserted on the 3rd beat of len=6 -> all outputs at reset values next cycle; no done; a new start then runs cleanly.
REQ-040 start pulsed while busy -> ignored; the original burst completes unchanged.
